// File: rtl/cntr_param.sv
// cntr_param: up/down counter with a six-state control FSM, programmable step, wrap/saturate mode, terminal-count and overflow flags
module cntr_param #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              en,
  input  logic              load,
  input  logic              inc,
  input  logic [STEP_W-1:0] step,
  input  logic              sat,
  input  logic [WIDTH-1:0]  d_in,
  output logic [WIDTH-1:0]  d_out,
  output logic [2:0]        o_state,
  output logic              tc,
  output logic              ovf
);
  typedef enum logic [2:0] {IDLE = 3'b000, LOAD = 3'b001, INC = 3'b010, INC2 = 3'b011, DEC = 3'b100, DEC2 = 3'b101} state_t;
  state_t state, nxt;
  logic [WIDTH+1:0] stp, delta, r;
  logic [WIDTH-1:0] d_nxt;
  logic illegal, arith, oor;
  always_comb begin
    illegal = state > DEC2;
    nxt = load ? LOAD :
          (state == INC && inc) ? INC2 :
          (state == DEC && !inc) ? DEC2 :
          inc ? INC : DEC;
    arith = nxt != LOAD;
    stp = {{(WIDTH+2-STEP_W){1'b0}}, step};
    delta = (nxt == INC2 || nxt == DEC2) ? stp << 1 : stp;
    r = (nxt == INC || nxt == INC2) ? {2'b00, d_out} + delta : {2'b00, d_out} - delta;
    // r[WIDTH+1] flags a negative result, r[WIDTH] alone a result above the maximum
    oor = r[WIDTH+1] | r[WIDTH];
    d_nxt = !arith ? d_in :
            (oor && sat) ? (r[WIDTH+1] ? '0 : '1) :
            r[WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      d_out <= '0;
      ovf   <= 1'b0;
    end else if (clr || illegal) begin
      state <= IDLE;
      d_out <= '0;
      ovf   <= 1'b0;
    end else if (!en) begin
      ovf <= 1'b0;
    end else begin
      state <= nxt;
      d_out <= d_nxt;
      ovf   <= arith & oor;
    end
  end
  assign o_state = state;
  assign tc = ((state == INC || state == INC2) && d_out == {WIDTH{1'b1}}) ||
              ((state == DEC || state == DEC2) && d_out == '0);
endmodule

// File: tb/tb_cntr_param.sv
// tb_cntr_param: directed vector table plus reset sequences for cntr_param (WIDTH=8, STEP_W=4)
module tb_cntr_param;
  logic clk = 1'b0, reset_n = 1'b0, clr = 1'b0, en = 1'b0, load = 1'b0, inc = 1'b0, sat = 1'b0;
  logic [3:0] step = '0;
  logic [7:0] d_in = '0, d_out;
  logic [2:0] o_state;
  logic tc, ovf;
  int passed = 0, total = 0;

  cntr_param #(.WIDTH(8), .STEP_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .en(en), .load(load), .inc(inc),
    .step(step), .sat(sat), .d_in(d_in), .d_out(d_out), .o_state(o_state), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic clr, en, load, inc, sat;
    logic [3:0] step;
    logic [7:0] d_in, d;
    logic [2:0] st;
    logic tc, ovf;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    else passed++;
  endtask

  task automatic chk_all(input int idx, input logic [7:0] d, input logic [2:0] st, input logic t, input logic o);
    chk("d_out", idx, 32'(d_out), 32'(d));
    chk("o_state", idx, 32'(o_state), 32'(st));
    chk("tc", idx, 32'(tc), 32'(t));
    chk("ovf", idx, 32'(ovf), 32'(o));
  endtask

  initial begin
    //            clr en ld inc sat step d_in   d      st    tc ovf
    v.push_back('{0, 1, 1, 0, 0, 4'd1, 8'hFC, 8'hFC, 3'b001, 0, 0});
    v.push_back('{0, 1, 0, 1, 0, 4'd1, 8'h00, 8'hFD, 3'b010, 0, 0});
    v.push_back('{0, 1, 0, 1, 0, 4'd1, 8'h00, 8'hFF, 3'b011, 1, 0});
    v.push_back('{0, 1, 0, 1, 0, 4'd1, 8'h00, 8'h00, 3'b010, 0, 1});
    v.push_back('{0, 1, 1, 1, 1, 4'd1, 8'hFC, 8'hFC, 3'b001, 0, 0});
    v.push_back('{0, 1, 0, 1, 1, 4'd1, 8'h00, 8'hFD, 3'b010, 0, 0});
    v.push_back('{0, 1, 0, 1, 1, 4'd1, 8'h00, 8'hFF, 3'b011, 1, 0});
    v.push_back('{0, 1, 0, 1, 1, 4'd1, 8'h00, 8'hFF, 3'b010, 1, 1});
    v.push_back('{0, 1, 0, 1, 1, 4'd1, 8'h00, 8'hFF, 3'b011, 1, 1});
    v.push_back('{0, 1, 1, 0, 0, 4'd2, 8'h03, 8'h03, 3'b001, 0, 0});
    v.push_back('{0, 1, 0, 0, 0, 4'd2, 8'h00, 8'h01, 3'b100, 0, 0});
    v.push_back('{0, 1, 0, 0, 0, 4'd2, 8'h00, 8'hFD, 3'b101, 0, 1});
    v.push_back('{0, 1, 1, 0, 1, 4'd2, 8'h03, 8'h03, 3'b001, 0, 0});
    v.push_back('{0, 1, 0, 0, 1, 4'd2, 8'h00, 8'h01, 3'b100, 0, 0});
    v.push_back('{0, 1, 0, 0, 1, 4'd2, 8'h00, 8'h00, 3'b101, 1, 1});
    v.push_back('{0, 0, 0, 0, 1, 4'd2, 8'h00, 8'h00, 3'b101, 1, 0});
    v.push_back('{0, 1, 1, 1, 0, 4'd1, 8'h0F, 8'h0F, 3'b001, 0, 0});
    v.push_back('{0, 1, 0, 1, 0, 4'd1, 8'h00, 8'h10, 3'b010, 0, 0});
    v.push_back('{0, 0, 1, 1, 0, 4'd1, 8'hAA, 8'h10, 3'b010, 0, 0});
    v.push_back('{0, 0, 1, 1, 0, 4'd1, 8'hAA, 8'h10, 3'b010, 0, 0});
    v.push_back('{0, 0, 1, 1, 0, 4'd1, 8'hAA, 8'h10, 3'b010, 0, 0});
    v.push_back('{0, 1, 1, 1, 0, 4'd1, 8'h5A, 8'h5A, 3'b001, 0, 0});
    v.push_back('{1, 1, 1, 1, 0, 4'd1, 8'h77, 8'h00, 3'b000, 0, 0});
    v.push_back('{0, 1, 1, 1, 0, 4'd3, 8'h80, 8'h80, 3'b001, 0, 0});
    v.push_back('{0, 1, 0, 1, 0, 4'd3, 8'h00, 8'h83, 3'b010, 0, 0});
    v.push_back('{0, 1, 0, 1, 0, 4'd3, 8'h00, 8'h89, 3'b011, 0, 0});
    v.push_back('{0, 1, 0, 0, 0, 4'd3, 8'h00, 8'h86, 3'b100, 0, 0});
    v.push_back('{0, 1, 0, 0, 0, 4'd3, 8'h00, 8'h80, 3'b101, 0, 0});
    v.push_back('{0, 1, 0, 1, 0, 4'd3, 8'h00, 8'h83, 3'b010, 0, 0});
    v.push_back('{0, 1, 0, 1, 0, 4'd0, 8'h00, 8'h83, 3'b011, 0, 0});
    v.push_back('{0, 1, 0, 0, 0, 4'd0, 8'h00, 8'h83, 3'b100, 0, 0});
    v.push_back('{1, 1, 0, 0, 0, 4'd1, 8'h00, 8'h00, 3'b000, 0, 0});

    #2 chk_all(-1, 8'h00, 3'b000, 1'b0, 1'b0);
    #10 reset_n = 1'b1;
    foreach (v[i]) begin
      {clr, en, load, inc, sat, step, d_in} = {v[i].clr, v[i].en, v[i].load, v[i].inc, v[i].sat, v[i].step, v[i].d_in};
      @(posedge clk);
      #1 chk_all(i, v[i].d, v[i].st, v[i].tc, v[i].ovf);
    end

    // async reset while counting in INC2 at 0x37, then restart cleanly
    {clr, en, load, inc, sat, step, d_in} = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 8'h34};
    @(posedge clk); #1 load = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 chk_all(100, 8'h37, 3'b011, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk_all(101, 8'h00, 3'b000, 1'b0, 1'b0);
    #3 reset_n = 1'b1;
    @(posedge clk); #1 chk_all(102, 8'h01, 3'b010, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
